// File: rtl/debounce_fsm.sv
`default_nettype none
//=============================================================================
// Module      : debounce_fsm
// Description : Switch/button debouncer driven by a slow sampling tick.
//               The sampled input must hold a new value for STABLE_TICKS
//               consecutive ticks before the debounced level follows it.
//               Emits registered one-cycle rise/fall pulses on acceptance.
//               Optional macro DEBOUNCE_SYNC_EN inserts a 2-flop input
//               synchroniser in front of the state machine.
// Revision    : 1.0 - initial release
//=============================================================================
module debounce_fsm #(
   parameter int STABLE_TICKS = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic sw,
   output logic db_level,
   output logic db_rise,
   output logic db_fall
);

   localparam int c_cnt_w = ($clog2(STABLE_TICKS) < 1) ? 1 : $clog2(STABLE_TICKS);
   localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(STABLE_TICKS - 1);

   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      WAIT1 = 2'd1,
      ONE   = 2'd2,
      WAIT0 = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_cnt_w-1:0] r_cnt;
   logic [c_cnt_w-1:0] w_cnt_nxt;
   logic               r_level;
   logic               r_rise;
   logic               r_fall;
   logic               w_rise_nxt;
   logic               w_fall_nxt;
   logic               w_level_nxt;
   logic               w_sw_s;

`ifdef DEBOUNCE_SYNC_EN
   logic r_sync1;
   logic r_sync2;

   // Two-flop synchroniser bringing the raw switch into the clk domain
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= sw;
         r_sync2 <= r_sync1;
      end
   end

   assign w_sw_s = r_sync2;
`else
   // Input is already synchronous to clk; sample it directly
   assign w_sw_s = sw;
`endif

   // Next-state, counter and pulse decode; an input reverting during a wait
   // state always wins over a coincident tick so a bounce never gets accepted
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rise_nxt  = 1'b0;
      w_fall_nxt  = 1'b0;
      case (r_state)
         ZERO: begin
            if (w_sw_s) begin
               w_state_nxt = WAIT1;
               w_cnt_nxt   = c_cnt_load;
            end
         end
         WAIT1: begin
            if (!w_sw_s) begin
               w_state_nxt = ZERO;
            end else if (tick) begin
               if (r_cnt == '0) begin
                  w_state_nxt = ONE;
                  w_rise_nxt  = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
         end
         ONE: begin
            if (!w_sw_s) begin
               w_state_nxt = WAIT0;
               w_cnt_nxt   = c_cnt_load;
            end
         end
         WAIT0: begin
            if (w_sw_s) begin
               w_state_nxt = ONE;
            end else if (tick) begin
               if (r_cnt == '0) begin
                  w_state_nxt = ZERO;
                  w_fall_nxt  = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt - 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ZERO;
         end
      endcase
   end

   // Level is high while accepted-one, including while a release is pending
   assign w_level_nxt = (w_state_nxt == ONE) || (w_state_nxt == WAIT0);

   // State, counter and registered outputs; reset abandons any pending count
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ZERO;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
         r_rise  <= w_rise_nxt;
         r_fall  <= w_fall_nxt;
      end
   end

   assign db_level = r_level;
   assign db_rise  = r_rise;
   assign db_fall  = r_fall;

endmodule
`default_nettype wire

// File: doc/debounce_fsm.md
# debounce_fsm

- Debounces one mechanical switch/button input for the board-level designs.
- Sits directly downstream of the 10 ms ticker and uses its `tick` strobe as the sampling time base.
- Produces a clean, glitch-free level plus one-cycle rising and falling edge pulses for the control logic.
- The input must stay stable for `STABLE_TICKS` consecutive ticks before the output level changes.

## Interface
- `STABLE_TICKS`, default 3: number of ticks the new input value must persist before it is accepted; legal range 1–255.
- `clk`  input  1  system clock (100 MHz on board).
- `reset`  input  1  reset; synchronous, active-low (`reset == 0` resets on the next `posedge clk`).
- `tick`  input  1  one-`clk`-wide strobe from the ticker, every 10 ms.
- `sw`  input  1  raw switch/button input.
- `db_level`  output  1  debounced level; registered.
- `db_rise`  output  1  one-cycle pulse when `db_level` goes 0→1; registered.
- `db_fall`  output  1  one-cycle pulse when `db_level` goes 1→0; registered.

## Operation
- **Registers.** State register is 2 bits, encoded ZERO, WAIT1, ONE, WAIT0. Down-counter `cnt` is `max(1, $clog2(STABLE_TICKS))` bits wide.
- **Sampling.** `sw_s` is the sampled input. It equals `sw` directly, or the synchronised copy described under Configuration.
- **ZERO:**
  - `sw_s == 1` → go to WAIT1 and load `cnt = STABLE_TICKS-1`.
  - Otherwise stay in ZERO.
- **WAIT1:**
  - `sw_s == 0` → go to ZERO. This takes priority over a `tick` in the same cycle.
  - Else, on `tick` with `cnt == 0` → go to ONE.
  - Else, on `tick` → `cnt <= cnt-1`.
  - No `tick` → hold.
- **ONE:**
  - `sw_s == 0` → go to WAIT0 and load `cnt = STABLE_TICKS-1`.
- **WAIT0:** mirror of WAIT1.
  - `sw_s == 1` → go to ONE (priority over `tick`).
  - On `tick` with `cnt == 0` → go to ZERO.
  - Else, on `tick` → decrement `cnt`.
- **Outputs.**
  - `db_level` is 1 in ONE and in WAIT0, and 0 in ZERO and in WAIT1.
  - `db_rise` is 1 for exactly the first cycle in ONE after WAIT1 (WAIT1→ONE transition).
  - `db_fall` is 1 for exactly the first cycle in ZERO after WAIT0 (WAIT0→ZERO transition).
  - Returning WAIT0→ONE or WAIT1→ZERO (bounce aborted) produces no pulse.
- **Reset.**
  - State goes to ZERO and `cnt` to 0.
  - `db_level`, `db_rise` and `db_fall` all go to 0.
  - Synchroniser flops (if compiled in) go to 0.
  - Reset mid-WAIT1/WAIT0 abandons the count with no pulse.
  - Reset takes priority over everything.
- **Counter.** `cnt` never underflows; a `tick` when `cnt == 0` always exits the wait state.

## Timing
- Acceptance latency is counted from the first cycle `sw_s` differs from `db_level`.
  - Counted in ticks: `STABLE_TICKS` ticks.
  - In wall time: `(STABLE_TICKS-1)×10 ms` to `STABLE_TICKS×10 ms`, plus 1 `clk`.
  - Default case: 20–30 ms.
- `db_level` and its pulse change on the `clk` edge after the accepting `tick` cycle.
- `tick` is assumed to be one cycle wide. A `tick` held high for k cycles counts as k ticks; this is not guarded.
- Pulses never overlap: at most one of `db_rise`/`db_fall` is high in any cycle.
- The minimum spacing between two pulses is `STABLE_TICKS` ticks.

## Configuration
- **Macro:** `DEBOUNCE_SYNC_EN`.
- **Defined:**
  - `sw` passes through a 2-flop synchroniser (both flops reset to 0), so `sw_s` is `sw` delayed 2 `clk`.
  - All latencies above gain 2 cycles.
- **Undefined:**
  - `sw_s = sw` combinationally.
  - For use only when `sw` is already synchronous to `clk`.

## Test plan
- All cases use `STABLE_TICKS = 3`, a tick every 10 `clk` (scaled), and `sw` synchronous. Run the suite with and without the macro.
- **Reset:** hold `reset = 0` for 3 cycles with `sw = 1` and ticks running → `db_level = db_rise = db_fall = 0` throughout.
- **Clean press:** `sw` 0→1 and hold → `db_level` rises on the cycle after the 3rd tick following the change, with `db_rise` high for exactly 1 cycle.
- **Bounce:** `sw` pulses 1 for 15 `clk` (spanning 1 tick), then returns to 0 → `db_level` stays 0 and no pulse occurs.
- **Release:** from the debounced-1 state, drop `sw` and hold for 3 ticks → `db_fall` pulses once and `db_level = 0`.
- **Bounce-back on final tick:** `sw` returns to 0 in the same cycle as the 3rd `tick` → state returns to ZERO and no `db_rise`.
- **Reset mid-operation:** assert `reset = 0` in WAIT1 after 2 ticks, release it, and keep `sw = 1` → a full 3 further ticks are needed before `db_rise`.
